// File: rtl/rs_encoder_c1_pkg.sv
// rtl/rs_encoder_c1_pkg.sv - shared GF(256) / RS(n,k) constants and encoder state type
package rs_encoder_c1_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int         RS_NPAR = 4;

  // g(x) = (x+a^0)(x+a^1)(x+a^2)(x+a^3) = x^4 + 15x^3 + 54x^2 + 120x + 64
  localparam logic [7:0] RS_G3 = 8'd15;
  localparam logic [7:0] RS_G2 = 8'd54;
  localparam logic [7:0] RS_G1 = 8'd120;
  localparam logic [7:0] RS_G0 = 8'd64;

  typedef enum logic {
    MSG = 1'b0,
    PAR = 1'b1
  } rs_state_e;

endpackage

// File: rtl/gf256_mult.sv
// rtl/gf256_mult.sv - combinational GF(256) multiplier, field polynomial 0x11D
module gf256_mult
  import rs_encoder_c1_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add; each shift of a is a multiply by alpha with reduction.
  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    p_o = acc;
  end

endmodule

// File: rtl/rs_encoder_c1.sv
// rtl/rs_encoder_c1.sv - systematic RS(K+4,K) encoder over GF(256), message pass-through then 4 parity
module rs_encoder_c1
  import rs_encoder_c1_pkg::*;
#(
  parameter int K = 28
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last
);

  localparam int CNT_W = $clog2((K > RS_NPAR) ? K : RS_NPAR);

  rs_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RS_NPAR-1:0][7:0] par_q, par_d;
  logic [7:0]              fb;
  logic [RS_NPAR-1:0][7:0] prod;

  assign fb = i_data ^ par_q[3];

  gf256_mult u_mul0 (.a_i(fb), .b_i(RS_G0), .p_o(prod[0]));
  gf256_mult u_mul1 (.a_i(fb), .b_i(RS_G1), .p_o(prod[1]));
  gf256_mult u_mul2 (.a_i(fb), .b_i(RS_G2), .p_o(prod[2]));
  gf256_mult u_mul3 (.a_i(fb), .b_i(RS_G3), .p_o(prod[3]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    o_data  = i_data;
    o_valid = i_valid;
    o_ready = i_ready;
    o_last  = 1'b0;
    unique case (state_q)
      MSG: begin
        if (i_valid && i_ready) begin
          par_d[3] = par_q[2] ^ prod[3];
          par_d[2] = par_q[1] ^ prod[2];
          par_d[1] = par_q[0] ^ prod[1];
          par_d[0] = prod[0];
          if (cnt_q == CNT_W'(K - 1)) begin
            cnt_d   = '0;
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        o_ready = 1'b0;
        o_valid = 1'b1;
        o_data  = par_q[3];
        o_last  = (cnt_q == CNT_W'(RS_NPAR - 1));
        // Shifting zeros in leaves the register clean for the next codeword.
        if (i_ready) begin
          par_d = {par_q[2:0], 8'h00};
          if (cnt_q == CNT_W'(RS_NPAR - 1)) begin
            cnt_d   = '0;
            state_d = MSG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = MSG;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MSG;
      cnt_q   <= '0;
      par_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_rs_encoder_c1.sv
// tb/tb_rs_encoder_c1.sv - self-checking bench for rs_encoder_c1 (K=28)
module tb_rs_encoder_c1;

  localparam int K = 28;
  localparam int N = K + 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_ready;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] out_q[$];
  int         gexp[0:254];
  int         glog[0:255];
  int         gpoly[0:4];

  typedef struct {
    string      name;
    logic [7:0] last_byte;
    logic [31:0] par;
  } vec_t;

  vec_t tbl[3];

  rs_encoder_c1 #(.K(K)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_last (o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Reference parity: remainder of m(x)*x^4 divided by g(x), by long division.
  function automatic logic [31:0] ref_parity(input logic [7:0] msg[$], input int base);
    int d[N];
    int c;
    for (int i = 0; i < N; i++) d[i] = (i < K) ? int'(msg[base + i]) : 0;
    for (int i = 0; i < K; i++) begin
      c = d[i];
      for (int j = 1; j <= 4; j++) d[i + j] = d[i + j] ^ gmul(c, gpoly[j]);
    end
    return {d[K][7:0], d[K+1][7:0], d[K+2][7:0], d[K+3][7:0]};
  endfunction

  // Output monitor: collects accepted symbols, checks PAR handshake and stall stability.
  initial begin
    int         sym_pos;
    bit         prev_stall;
    logic [8:0] prev_sym;
    sym_pos    = 0;
    prev_stall = 0;
    prev_sym   = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        sym_pos    = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) chk("stall_hold", {23'd0, o_valid, o_last, o_data}, {23'd0, 1'b1, prev_sym});
        if (sym_pos >= K) chk("par_handshake", {30'd0, o_valid, o_ready}, 32'd2);
        prev_stall = o_valid && !i_ready;
        prev_sym   = {o_last, o_data};
        if (o_valid && i_ready) begin
          out_q.push_back({o_last, o_data});
          sym_pos = (sym_pos + 1) % N;
        end
      end
    end
  end

  task automatic run_stream(input logic [7:0] msg[$], input int vpct, input int rpct);
    int idx, got, guard, total;
    bit xin, xout;
    idx = 0; got = 0; guard = 0;
    total = (msg.size() / K) * N;
    out_q.delete();
    while (got < total && guard < 5000) begin
      i_ready = ($urandom_range(99) >= rpct);
      if (!i_valid && idx < msg.size() && $urandom_range(99) >= vpct) begin
        i_valid = 1'b1;
        i_data  = msg[idx];
      end
      @(negedge i_clk);
      xin  = i_valid && o_ready;
      xout = o_valid && i_ready;
      @(posedge i_clk);
      #1;
      if (xin) begin
        idx++;
        i_valid = 1'b0;
      end
      if (xout) got++;
      guard++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    if (guard >= 5000) chk("stream_timeout", 32'(got), 32'(total));
  endtask

  task automatic check_stream(input string name, input logic [7:0] msg[$]);
    int ncw, syn;
    logic [31:0] par;
    logic [7:0]  cw[N];
    ncw = msg.size() / K;
    chk({name, "_count"}, 32'(out_q.size()), 32'(ncw * N));
    if (out_q.size() == ncw * N) begin
      for (int w = 0; w < ncw; w++) begin
        par = ref_parity(msg, w * K);
        for (int i = 0; i < N; i++) begin
          if (i < K) chk({name, "_msg"}, 32'(out_q[w*N + i]), {23'd0, 1'b0, msg[w*K + i]});
          else chk({name, "_par"}, 32'(out_q[w*N + i]),
                   {23'd0, (i == N - 1), par[8*(N-1-i) +: 8]});
          cw[i] = out_q[w*N + i][7:0];
        end
        for (int j = 0; j < 4; j++) begin
          syn = 0;
          for (int i = 0; i < N; i++) syn = gmul(syn, gexp[j]) ^ int'(cw[i]);
          chk({name, "_syndrome"}, 32'(syn), 32'd0);
        end
      end
    end
  endtask

  task automatic check_fixed(input string name, input logic [7:0] last_byte, input logic [31:0] par);
    logic [7:0] msg[$];
    for (int i = 0; i < K; i++) msg.push_back((i == K - 1) ? last_byte : 8'h00);
    run_stream(msg, 0, 0);
    chk({name, "_count"}, 32'(out_q.size()), 32'(N));
    if (out_q.size() == N) begin
      for (int i = 0; i < 4; i++)
        chk({name, "_par"}, 32'(out_q[K + i]), {23'd0, (i == 3), par[8*(3-i) +: 8]});
      chk({name, "_lastbyte"}, 32'(out_q[K-1]), {24'd0, last_byte});
    end
  endtask

  initial begin
    logic [7:0] msg[$];
    int         x;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if (x & 256) x = x ^ 'h11D;
    end
    glog[0] = 0;
    gpoly = '{1, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++)
      for (int j = 4; j >= 1; j--) gpoly[j] = gpoly[j] ^ gmul(gpoly[j-1], gexp[i]);

    tbl[0] = '{"zero_msg", 8'h00, 32'h00000000};
    tbl[1] = '{"unit_msg", 8'h01, 32'h0F367840};
    tbl[2] = '{"two_msg",  8'h02, 32'h1E6CF080};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = 8'h5A;
    @(negedge i_clk);
    chk("reset_idle", {20'd0, o_valid, o_ready, o_last, 1'b0, o_data}, {20'd0, 4'b0100, 8'h5A});
    i_valid = 1'b1; i_data = 8'hC3; i_ready = 1'b0;
    @(negedge i_clk);
    chk("reset_passthru", {20'd0, o_valid, o_ready, o_last, 1'b0, o_data}, {20'd0, 4'b1000, 8'hC3});
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;

    foreach (tbl[t]) check_fixed(tbl[t].name, tbl[t].last_byte, tbl[t].par);

    for (int r = 0; r < 6; r++) begin
      msg.delete();
      for (int i = 0; i < K * (1 + r % 2); i++) msg.push_back(8'($urandom_range(255)));
      run_stream(msg, (r < 2) ? 0 : 30, (r < 2) ? 0 : 40);
      check_stream("random", msg);
    end

    msg.delete();
    for (int i = 0; i < 2 * K; i++) msg.push_back(8'($urandom_range(255)));
    run_stream(msg, 0, 0);
    check_stream("back_to_back", msg);

    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_ready = 1'b1; i_data = 8'($urandom_range(1, 255));
      @(posedge i_clk); #1;
    end
    #3 i_rst = 1'b1; i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_fixed("reset_mid", 8'h01, 32'h0F367840);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
